instr_mem_loader: RTL and testbench

- Writer side of the instruction memory: fills it at run time instead of from a file at elaboration.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word to consecutive instruction-memory addresses starting at 0.
- Sits between a host/debug byte source (UART RX, testbench driver) and the instruction-memory write port; reports busy/done/error to the control logic.

---
 rtl/instr_mem_loader.sv | 149 ++++++++++++++
 tb/tb_instr_mem_loader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a little-endian byte stream into 32-bit words and writes them from address 0.
// Define INSTR_MEM_LOADER_CSUM_EN to add a trailing XOR checksum byte and a csum_err flag.
module instr_mem_loader #(
  parameter int DEPTH  = 8000,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] num_words,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
`ifdef INSTR_MEM_LOADER_CSUM_EN
  output logic              csum_err,
`endif
  output logic              err_len
);
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
`ifdef INSTR_MEM_LOADER_CSUM_EN
    CSUM,
`endif
    DONE
  } state_t;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q, addr_q;
  logic [1:0]        bcnt_q;
  logic [31:0]       word_q;
  logic              rdy_q, we_q, busy_q, done_q, err_q;
  logic              len_bad, last_word;
`ifdef INSTR_MEM_LOADER_CSUM_EN
  logic [7:0]        xor_q;
  logic              cerr_q;
  assign csum_err = cerr_q;
`endif
  assign len_bad    = {1'b0, num_words} > DEPTH_W;
  assign last_word  = addr_q == cnt_q - ADDR_W'(1);
  // abort takes effect in its own cycle, so the strobes are masked combinationally
  assign byte_ready = rdy_q & ~abort;
  assign mem_we     = we_q & ~abort;
  assign done       = done_q & ~abort;
  assign busy       = busy_q;
  assign err_len    = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = word_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef INSTR_MEM_LOADER_CSUM_EN
      xor_q   <= '0;
      cerr_q  <= 1'b0;
`endif
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        rdy_q   <= 1'b0;
        busy_q  <= 1'b0;
        bcnt_q  <= '0;
      end else begin
        case (state_q)
          IDLE: if (start) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              err_q  <= 1'b0;
              cnt_q  <= num_words;
              addr_q <= '0;
              bcnt_q <= '0;
              busy_q <= 1'b1;
`ifdef INSTR_MEM_LOADER_CSUM_EN
              xor_q   <= '0;
              cerr_q  <= 1'b0;
              state_q <= (num_words == '0) ? CSUM : LOAD;
              rdy_q   <= 1'b1;
`else
              state_q <= (num_words == '0) ? DONE : LOAD;
              rdy_q   <= num_words != '0;
              done_q  <= num_words == '0;
`endif
            end
          end
          LOAD: if (byte_valid) begin
            word_q[{bcnt_q, 3'b000} +: 8] <= byte_data;
            bcnt_q <= bcnt_q + 2'd1;
`ifdef INSTR_MEM_LOADER_CSUM_EN
            xor_q <= xor_q ^ byte_data;
`endif
            if (bcnt_q == 2'd3) begin
              state_q <= WRITE;
              rdy_q   <= 1'b0;
              we_q    <= 1'b1;
            end
          end
          WRITE: if (last_word) begin
`ifdef INSTR_MEM_LOADER_CSUM_EN
            state_q <= CSUM;
            rdy_q   <= 1'b1;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end else begin
            addr_q  <= addr_q + ADDR_W'(1);
            state_q <= LOAD;
            rdy_q   <= 1'b1;
          end
`ifdef INSTR_MEM_LOADER_CSUM_EN
          CSUM: if (byte_valid) begin
            cerr_q  <= byte_data != xor_q;
            state_q <= DONE;
            rdy_q   <= 1'b0;
            done_q  <= 1'b1;
          end
`endif
          DONE: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: cycle-by-cycle vector table for the loader plus hand sequences for reset and checksum.
module tb_instr_mem_loader;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [12:0] num_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, busy, done, err_len;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;
`ifdef INSTR_MEM_LOADER_CSUM_EN
  logic        csum_err;
`endif
  int errs = 0, checks = 0;
  instr_mem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done),
`ifdef INSTR_MEM_LOADER_CSUM_EN
    .csum_err(csum_err),
`endif
    .err_len(err_len)
  );
  always #5 clk = ~clk;
  // flags order: {byte_ready, mem_we, busy, done, err_len}
  typedef struct {
    logic        st;
    logic [12:0] nw;
    logic        ab;
    logic        bv;
    logic [7:0]  bd;
    logic [4:0]  ef;
    logic [12:0] ea;
    logic [31:0] ed;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(logic st, logic [12:0] nw, logic ab, logic bv, logic [7:0] bd,
                              logic [4:0] ef, logic [12:0] ea = '0, logic [31:0] ed = '0);
    vec_t v;
    v.st = st; v.nw = nw; v.ab = ab; v.bv = bv; v.bd = bd; v.ef = ef; v.ea = ea; v.ed = ed;
    return v;
  endfunction
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  function automatic logic [4:0] flags();
    return {byte_ready, mem_we, busy, done, err_len};
  endfunction
  task automatic drive(input logic st, input logic [12:0] nw, input logic ab, input logic bv, input logic [7:0] bd);
    @(negedge clk);
    start = st; num_words = nw; abort = ab; byte_valid = bv; byte_data = bd;
    #1;
  endtask
  initial begin
    #1;
    chk("reset flags", 64'(flags()), 0);
    chk("reset addr/data", {mem_addr, mem_wdata}, 0);
    @(negedge clk) rst_n = 1'b1;
`ifndef INSTR_MEM_LOADER_CSUM_EN
    // two words back-to-back
    tv.push_back(mk(1, 2, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(0, 0, 0, 1, 8'h13, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b01100, 0, 32'h00000013));
    tv.push_back(mk(0, 0, 0, 1, 8'h93, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h10, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h00, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b01100, 1, 32'h00100093));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00110));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00000));
    // gapped stream, junk on byte_data while invalid
    tv.push_back(mk(1, 1, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(0, 0, 0, 1, 8'hEF, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'hFF, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'hBE, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'hFF, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'hAD, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'hFF, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'hDE, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b01100, 0, 32'hDEADBEEF));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00110));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00000));
    // length error, start+abort keeps err, DEPTH itself is accepted
    tv.push_back(mk(1, 8001, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00001));
    tv.push_back(mk(1, 1, 1, 0, 8'h00, 5'b00001));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00001));
    tv.push_back(mk(1, 8000, 0, 0, 8'h00, 5'b00001));
    tv.push_back(mk(0, 0, 1, 1, 8'h55, 5'b00100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00000));
    // abort after six bytes, then reload from address 0
    tv.push_back(mk(1, 3, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(0, 0, 0, 1, 8'h11, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h22, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h33, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h44, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b01100, 0, 32'h44332211));
    tv.push_back(mk(0, 0, 0, 1, 8'h55, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h66, 5'b10100));
    tv.push_back(mk(0, 0, 1, 1, 8'h77, 5'b00100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(1, 1, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(0, 0, 0, 1, 8'hA1, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'hB2, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'hC3, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'hD4, 5'b10100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b01100, 0, 32'hD4C3B2A1));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00110));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00000));
    // abort in WRITE suppresses the strobe and done
    tv.push_back(mk(1, 1, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(0, 0, 0, 1, 8'h01, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h02, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h03, 5'b10100));
    tv.push_back(mk(0, 0, 0, 1, 8'h04, 5'b10100));
    tv.push_back(mk(0, 0, 1, 0, 8'h00, 5'b00100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00000));
    // abort in DONE suppresses done
    tv.push_back(mk(1, 0, 0, 0, 8'h00, 5'b00000));
    tv.push_back(mk(0, 0, 1, 0, 8'h00, 5'b00100));
    tv.push_back(mk(0, 0, 0, 0, 8'h00, 5'b00000));
    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].st, tv[i].nw, tv[i].ab, tv[i].bv, tv[i].bd);
      chk($sformatf("v%0d flags", i), 64'(flags()), 64'(tv[i].ef));
      if (tv[i].ef[3]) chk($sformatf("v%0d addr/data", i), {mem_addr, mem_wdata}, {tv[i].ea, tv[i].ed});
    end
    // async reset after two bytes, no clock edge involved
    drive(1, 2, 0, 0, 8'h00);
    drive(0, 0, 0, 1, 8'hAA);
    drive(0, 0, 0, 1, 8'hBB);
    drive(0, 0, 0, 0, 8'h00);
    chk("pre-reset busy", 64'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset flags", 64'(flags()), 0);
    chk("async reset addr/data", {mem_addr, mem_wdata}, 0);
    @(negedge clk) rst_n = 1'b1;
    drive(1, 0, 0, 0, 8'h00);
    chk("zero-len start", 64'(flags()), 0);
    drive(0, 0, 0, 0, 8'h00);
    chk("zero-len done", 64'(flags()), 64'(5'b00110));
    drive(0, 0, 0, 0, 8'h00);
    chk("zero-len idle", 64'(flags()), 0);
`else
    for (int r = 0; r < 2; r++) begin
      drive(1, 1, 0, 0, 8'h00);
      drive(0, 0, 0, 1, 8'h01);
      drive(0, 0, 0, 1, 8'h02);
      drive(0, 0, 0, 1, 8'h04);
      drive(0, 0, 0, 1, 8'h08);
      drive(0, 0, 0, 0, 8'h00);
      chk($sformatf("csum%0d write", r), {59'(flags()), 5'b0}, {59'(5'b01100), 5'b0});
      chk($sformatf("csum%0d word", r), 64'(mem_wdata), 64'h0804_0201);
      drive(0, 0, 0, 0, 8'h00);
      chk($sformatf("csum%0d wait", r), 64'(flags()), 64'(5'b10100));
      drive(0, 0, 0, 1, r == 0 ? 8'h0F : 8'h0E);
      chk($sformatf("csum%0d accept", r), 64'(flags()), 64'(5'b10100));
      drive(0, 0, 0, 0, 8'h00);
      chk($sformatf("csum%0d done", r), 64'(flags()), 64'(5'b00110));
      chk($sformatf("csum%0d err", r), 64'(csum_err), 64'(r));
      drive(0, 0, 0, 0, 8'h00);
      chk($sformatf("csum%0d idle", r), 64'(flags()), 0);
    end
    drive(1, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    chk("csum zero-len wait", 64'(flags()), 64'(5'b10100));
    chk("csum err cleared", 64'(csum_err), 0);
    drive(0, 0, 0, 1, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    chk("csum zero-len done", 64'(flags()), 64'(5'b00110));
    chk("csum zero-len err", 64'(csum_err), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
